base_block_loader: RTL and testbench
====================================

// Module: base_block_loader
// PURPOSE
//  Parametrised operand sequencer feeding base_block_extended. Accepts a
//  word-serial stream (valid/ready) of features, filters and biases into
//  shadow registers, then issues them to the wide operand buses in a fixed
//  three-cycle pattern: features+filters, then biases with filters cleared,
//  then biases cleared. Sits between the host/DMA word stream and the block.
// PARAMETERS
//  BITS          16  operand width, features and filters
//  OVERHEAD_BITS 12  accumulator headroom bits
//  LANES         56  operands per bus; >=2
//  BIAS_BITS     2*BITS+OVERHEAD_BITS (44)  bias word width
//  CLEAR_EN      1   1: zero filters/biases after issue; 0: hold last value
// PORTS
//  clk       in   1                clock, all logic on posedge
//  rst_n     in   1                synchronous active-low reset
//  start     in   1                begin a load/issue sequence, sampled in IDLE only
//  abort     in   1                abandon a load in progress
//  in_data   in   BIAS_BITS        stream word
//  in_valid  in   1                in_data valid
//  in_ready  out  1                loader accepts in_data
//  features  out  LANES*BITS       feature bus to base block
//  filters   out  LANES*BITS       filter bus to base block
//  biases    out  LANES*BIAS_BITS  bias bus to base block
//  busy      out  1                state != IDLE
//  done      out  1                one-cycle pulse at end of issue
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, idx=0, features/filters/biases=0,
//    shadows=0, done=0. Reset mid-load or mid-issue discards everything.
//  - States: IDLE -> LD_FEAT -> LD_FILT -> LD_BIAS -> ISS_A -> ISS_B -> ISS_C
//    -> IDLE.
//  - IDLE: start=1 -> LD_FEAT, idx=0. start is ignored in all other states.
//  - LD_* states: in_ready = ~abort. Transfer = in_valid & in_ready.
//  - On a transfer, word goes to lane idx of the state's shadow, at bits
//    [idx*W +: W]. Features and filters take in_data[BITS-1:0]; upper bits
//    are ignored. Biases take the full word.
//  - idx increments per transfer. A transfer at idx=LANES-1 wraps idx to 0
//    and advances to the next state. Stalls (in_valid=0) hold idx.
//  - abort=1 in any LD_* state: -> IDLE next cycle, no word accepted that
//    cycle, output buses unchanged. Shadows keep their partial contents and
//    are overwritten by the next load. abort is ignored outside LD_* states.
//  - ISS_A: features<=feat_sh, filters<=filt_sh. Both update on the same edge.
//  - ISS_B: biases<=bias_sh. filters<=0 if CLEAR_EN, held otherwise.
//  - ISS_C: biases<=0 if CLEAR_EN, held otherwise. done=1 for this cycle only.
//    Next state is IDLE.
//  - features hold their issued value until the next ISS_A or reset.
//  - in_ready=0 in IDLE and ISS_*. Minimum sequence length is 3*LANES+3
//    cycles after start with in_valid held high.
//  - All outputs are registered. No combinational path from inputs to
//    outputs except abort -> in_ready.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles -> all buses 0, busy=0, in_ready=0, done=0.
//  2 Full sequence, in_valid=1 throughout. Feature words 1..56, filter words
//    1..56, bias words 56..1 -> after ISS_A, features lane0=1 and lane55=56,
//    filters same. After ISS_B, filters all 0 and biases lane0=56. After ISS_C,
//    biases all 0. done pulses once, 3*56+3 cycles after start.
//  3 Backpressure: in_valid toggles every other cycle -> identical bus
//    contents to scenario 2. idx never skips. Sequence takes about 2x longer.
//  4 Abort at filter idx=20, with in_valid=1 in the same cycle -> word not
//    accepted, IDLE next cycle, buses unchanged, no done pulse. Restart
//    completes correctly.
//  5 CLEAR_EN=0 -> after ISS_C, filters and biases retain the issued values.
//  6 Reset mid-LD_BIAS, then start -> prior shadow contents are not issued.
//    start during a load is ignored. in_data[43:16]=all-ones on a feature word
//    -> feature lane shows only the low 16 bits.

Source files
------------

// File: rtl/base_block_loader.sv
// base_block_loader: word-serial operand sequencer for base_block_extended.
// Collects LANES feature words, LANES filter words and LANES bias words into
// shadow registers, then drives the wide operand buses in three issue cycles:
// features+filters, then biases (filters cleared), then biases cleared.
module base_block_loader #(
  parameter int BITS          = 16,
  parameter int OVERHEAD_BITS = 12,
  parameter int LANES         = 56,
  parameter int BIAS_BITS     = 2*BITS+OVERHEAD_BITS,
  parameter int CLEAR_EN      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BIAS_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [LANES*BITS-1:0]      features,
  output logic [LANES*BITS-1:0]      filters,
  output logic [LANES*BIAS_BITS-1:0] biases,
  output logic                       busy,
  output logic                       done
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LANES-1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_FEAT = 3'd1;
  localparam logic [2:0] S_LD_FILT = 3'd2;
  localparam logic [2:0] S_LD_BIAS = 3'd3;
  localparam logic [2:0] S_ISS_A   = 3'd4;
  localparam logic [2:0] S_ISS_B   = 3'd5;
  localparam logic [2:0] S_ISS_C   = 3'd6;

  logic [2:0]                 state_q, state_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [LANES*BITS-1:0]      feat_sh_q, feat_sh_d;
  logic [LANES*BITS-1:0]      filt_sh_q, filt_sh_d;
  logic [LANES*BIAS_BITS-1:0] bias_sh_q, bias_sh_d;
  logic [LANES*BITS-1:0]      features_q, features_d;
  logic [LANES*BITS-1:0]      filters_q, filters_d;
  logic [LANES*BIAS_BITS-1:0] biases_q, biases_d;
  logic                       done_q, done_d;
  logic                       in_load;
  logic                       xfer;

  // abort must block acceptance in the same cycle, hence the only comb path to an output
  assign in_load  = (state_q == S_LD_FEAT) || (state_q == S_LD_FILT) || (state_q == S_LD_BIAS);
  assign in_ready = in_load & ~abort;
  assign xfer     = in_valid & in_ready;

  assign features = features_q;
  assign filters  = filters_q;
  assign biases   = biases_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);

  // Sequencer: load phases advance on the transfer that fills the last lane
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LD_FEAT;
          idx_d   = '0;
        end
      end
      S_LD_FEAT, S_LD_FILT, S_LD_BIAS: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (xfer) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            case (state_q)
              S_LD_FEAT: state_d = S_LD_FILT;
              S_LD_FILT: state_d = S_LD_BIAS;
              default:   state_d = S_ISS_A;
            endcase
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_ISS_A: state_d = S_ISS_B;
      S_ISS_B: state_d = S_ISS_C;
      S_ISS_C: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Shadow capture: only the lane at idx of the bank being loaded changes
  always_comb begin
    feat_sh_d = feat_sh_q;
    filt_sh_d = filt_sh_q;
    bias_sh_d = bias_sh_q;
    if (xfer) begin
      case (state_q)
        S_LD_FEAT: feat_sh_d[idx_q*BITS +: BITS] = in_data[BITS-1:0];
        S_LD_FILT: filt_sh_d[idx_q*BITS +: BITS] = in_data[BITS-1:0];
        S_LD_BIAS: bias_sh_d[idx_q*BIAS_BITS +: BIAS_BITS] = in_data;
        default: ;
      endcase
    end
  end

  // Issue pattern onto the operand buses; done marks the final issue cycle
  always_comb begin
    features_d = features_q;
    filters_d  = filters_q;
    biases_d   = biases_q;
    done_d     = (state_q == S_ISS_B);
    case (state_q)
      S_ISS_A: begin
        features_d = feat_sh_q;
        filters_d  = filt_sh_q;
      end
      S_ISS_B: begin
        biases_d = bias_sh_q;
        if (CLEAR_EN != 0) filters_d = '0;
      end
      S_ISS_C: begin
        if (CLEAR_EN != 0) biases_d = '0;
      end
      default: ;
    endcase
  end

  // State, shadows and buses all clear on reset so no stale operand is ever issued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      feat_sh_q  <= '0;
      filt_sh_q  <= '0;
      bias_sh_q  <= '0;
      features_q <= '0;
      filters_q  <= '0;
      biases_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      feat_sh_q  <= feat_sh_d;
      filt_sh_q  <= filt_sh_d;
      bias_sh_q  <= bias_sh_d;
      features_q <= features_d;
      filters_q  <= filters_d;
      biases_q   <= biases_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_base_block_loader.sv
// tb_base_block_loader: scenario tasks with a scoreboard of expected issued
// bus images. A second instance with CLEAR_EN=0 shares the same stimulus.
module tb_base_block_loader;

  localparam int BITS  = 16;
  localparam int OVH   = 12;
  localparam int LANES = 56;
  localparam int BB    = 2*BITS+OVH;
  localparam int FW    = LANES*BITS;
  localparam int BW    = LANES*BB;

  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid;
  logic [BB-1:0] in_data;
  logic in_ready, busy, done;
  logic in_ready0, busy0, done0;
  logic [FW-1:0] features, filters, features0, filters0;
  logic [BW-1:0] biases, biases0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;

  logic [FW-1:0] q_feat[$];
  logic [FW-1:0] q_filt[$];
  logic [BW-1:0] q_bias[$];
  logic [BB-1:0] words[3*LANES];

  base_block_loader #(.BITS(BITS), .OVERHEAD_BITS(OVH), .LANES(LANES), .CLEAR_EN(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .features(features), .filters(filters), .biases(biases),
    .busy(busy), .done(done));

  base_block_loader #(.BITS(BITS), .OVERHEAD_BITS(OVH), .LANES(LANES), .CLEAR_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .features(features0), .filters(filters0), .biases(biases0),
    .busy(busy0), .done(done0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic gen_words(input int mode);
    logic [63:0] r;
    for (int i = 0; i < LANES; i++) begin
      if (mode == 0) begin
        words[i]         = BB'(i+1);
        words[LANES+i]   = BB'(i+1);
        words[2*LANES+i] = BB'(LANES-i);
      end else begin
        r = {$urandom, $urandom}; words[i]         = r[BB-1:0];
        r = {$urandom, $urandom}; words[LANES+i]   = r[BB-1:0];
        r = {$urandom, $urandom}; words[2*LANES+i] = r[BB-1:0];
      end
    end
    if (mode == 2) words[0] = {{(BB-BITS){1'b1}}, 16'h1234};
  endtask

  task automatic push_exp();
    logic [FW-1:0] ef, efl;
    logic [BW-1:0] eb;
    for (int i = 0; i < LANES; i++) begin
      ef[i*BITS +: BITS]  = words[i][BITS-1:0];
      efl[i*BITS +: BITS] = words[LANES+i][BITS-1:0];
      eb[i*BB +: BB]      = words[2*LANES+i];
    end
    q_feat.push_back(ef);
    q_filt.push_back(efl);
    q_bias.push_back(eb);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic load_words(input int n, input bit stall, input bit pulse_start);
    bit ok;
    int t;
    for (int k = 0; k < n; k++) begin
      if (stall) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data  = words[k];
      in_valid = 1'b1;
      start    = pulse_start && (k >= 30) && (k < 34);
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 20) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) begin
        total++; bad++;
        $display("FAIL load_ready got in_ready=0 exp 1 at word %0d", k);
        break;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Waits for done, then checks the issued images against the scoreboard.
  // exp_lat is the number of clock edges from the start edge to the done cycle.
  task automatic wait_done(input int exp_lat);
    logic [FW-1:0] pf, ef, efl;
    logic [BW-1:0] eb;
    bit found;
    int lat, dc0;
    found = 1'b0;
    pf = '0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin found = 1'b1; break; end
      pf = filters;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL done_seen got no pulse exp pulse within 800 cycles");
      return;
    end
    total++;
    if (q_feat.size() == 0) begin
      bad++;
      $display("FAIL scoreboard got empty queue exp entry");
      return;
    end
    ef  = q_feat.pop_front();
    efl = q_filt.pop_front();
    eb  = q_bias.pop_front();
    lat = cyc - start_cyc;
    dc0 = done_cnt;
    if (exp_lat >= 0) begin
      total++;
      if (lat !== exp_lat) begin bad++; $display("FAIL latency got %0d exp %0d", lat, exp_lat); end
    end
    total++;
    if (features !== ef) begin bad++; $display("FAIL feat_issue got %h exp %h", features[63:0], ef[63:0]); end
    total++;
    if (pf !== efl) begin bad++; $display("FAIL filt_issue got %h exp %h", pf[63:0], efl[63:0]); end
    total++;
    if (filters !== '0) begin bad++; $display("FAIL filt_clear got %h exp 0", filters[63:0]); end
    total++;
    if (biases !== eb) begin bad++; $display("FAIL bias_issue got %h exp %h", biases[87:0], eb[87:0]); end
    total++;
    if (filters0 !== efl) begin bad++; $display("FAIL hold_filt got %h exp %h", filters0[63:0], efl[63:0]); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_width got %b exp 0", done); end
    total++;
    if (done_cnt !== dc0 + 1) begin bad++; $display("FAIL done_count got %0d exp %0d", done_cnt, dc0 + 1); end
    total++;
    if (biases !== '0) begin bad++; $display("FAIL bias_clear got %h exp 0", biases[87:0]); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b exp 0", busy); end
    total++;
    if (features !== ef) begin bad++; $display("FAIL feat_hold got %h exp %h", features[63:0], ef[63:0]); end
    total++;
    if (biases0 !== eb || filters0 !== efl) begin
      bad++; $display("FAIL hold_after_c got %h exp %h", biases0[87:0], eb[87:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (features !== '0 || filters !== '0 || biases !== '0) begin
      bad++; $display("FAIL reset_bus got %h exp 0", {features[31:0], filters[31:0], biases[43:0]});
    end
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got %b%b%b exp 000", busy, in_ready, done);
    end
    total++;
    if (features0 !== '0 || filters0 !== '0 || biases0 !== '0) begin
      bad++; $display("FAIL reset_bus0 got nonzero exp 0");
    end
  endtask

  task automatic test_full();
    gen_words(0);
    push_exp();
    do_start();
    load_words(3*LANES, 1'b0, 1'b0);
    wait_done(3*LANES+2);
    total++;
    if (features[0 +: BITS] !== 16'd1 || features[55*BITS +: BITS] !== 16'd56) begin
      bad++; $display("FAIL feat_lanes got %0d,%0d exp 1,56", features[0 +: BITS], features[55*BITS +: BITS]);
    end
    total++;
    if (biases0[0 +: BB] !== 44'd56) begin
      bad++; $display("FAIL bias_lane0 got %0d exp 56", biases0[0 +: BB]);
    end
  endtask

  task automatic test_backpressure();
    gen_words(0);
    push_exp();
    do_start();
    load_words(3*LANES, 1'b1, 1'b0);
    wait_done(6*LANES+2);
  endtask

  task automatic test_abort();
    logic [FW-1:0] sf, sfl;
    logic [BW-1:0] sb;
    int dc0;
    gen_words(1);
    do_start();
    load_words(LANES+20, 1'b0, 1'b0);
    sf = features; sfl = filters; sb = biases;
    dc0 = done_cnt;
    in_data  = words[LANES+20];
    in_valid = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_ready got %b exp 0", in_ready); end
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b exp 0", busy); end
    repeat (5) @(negedge clk);
    total++;
    if (features !== sf || filters !== sfl || biases !== sb) begin
      bad++; $display("FAIL abort_bus got %h exp %h", features[63:0], sf[63:0]);
    end
    total++;
    if (done_cnt !== dc0) begin bad++; $display("FAIL abort_done got %0d exp %0d", done_cnt, dc0); end
    gen_words(1);
    push_exp();
    do_start();
    load_words(3*LANES, 1'b0, 1'b0);
    wait_done(3*LANES+2);
  endtask

  task automatic test_reset_mid();
    gen_words(1);
    do_start();
    load_words(2*LANES+10, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (features !== '0 || filters !== '0 || biases !== '0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset got busy=%b feat=%h exp 0", busy, features[63:0]);
    end
    gen_words(2);
    push_exp();
    do_start();
    load_words(3*LANES, 1'b0, 1'b1);
    wait_done(3*LANES+2);
    total++;
    if (features[0 +: BITS] !== 16'h1234) begin
      bad++; $display("FAIL feat_trunc got %h exp 1234", features[0 +: BITS]);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    test_reset();
    test_full();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
